// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmit-line bundle for uart_tx_arbiter.
// Producers drive the master side. The arbiter owns the slave side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  localparam int unsigned GW = (NREQ < 2) ? 1 : $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx;
  logic              busy;
  logic [GW-1:0]     grant_id;

  modport master (
    output req_valid, req_data,
    input  req_ready, tx, busy, grant_id
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, tx, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART tx line among NREQ byte requesters.
// Each bit lasts CLKF/BR clocks. One requester is granted per frame.
module uart_tx_arbiter #(
  parameter int unsigned BR   = 115200,
  parameter int unsigned CLKF = 50000000,
  parameter int unsigned NREQ = 4
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned BIT_CYC = (BR == 0) ? 0 : CLKF / BR;
  localparam int unsigned BIT_REM = (BR == 0) ? 0 : CLKF % BR;
  localparam int unsigned BC_SAFE = (BIT_CYC < 2) ? 2 : BIT_CYC;
  localparam int unsigned CYC_W   = $clog2(BC_SAFE);
  localparam int unsigned GW      = (NREQ < 2) ? 1 : $clog2(NREQ);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BC_SAFE - 1);

  if (BR == 0) begin : g_bad_br
    $fatal(1, "uart_tx_arbiter: BR must be nonzero");
  end
  if (CLKF == 0) begin : g_bad_clkf
    $fatal(1, "uart_tx_arbiter: CLKF must be nonzero");
  end
  if (NREQ < 2) begin : g_bad_nreq
    $fatal(1, "uart_tx_arbiter: NREQ must be at least 2");
  end
  if (BR != 0 && (BIT_REM != 0 || BIT_CYC < 2)) begin : g_bad_bitcyc
    $fatal(1, "uart_tx_arbiter: CLKF/BR must be an integer >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;

  logic              any_valid;
  logic [GW-1:0]     win_idx;
  logic [GW-1:0]     cand_id;
  logic [NREQ-1:0]   ready;
  logic              bit_end;

  // The first valid requester after last_q, wrapping around, wins.
  always_comb begin
    any_valid = 1'b0;
    win_idx   = '0;
    cand_id   = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand_id = GW'((32'(last_q) + off) % NREQ);
      if (!any_valid && bus.req_valid[cand_id]) begin
        any_valid = 1'b1;
        win_idx   = cand_id;
      end
    end
  end

  assign bit_end = (cyc_q == CYC_LAST);

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q + CYC_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    grant_d = grant_q;
    last_d  = last_q;
    ready   = '0;

    case (state_q)
      S_IDLE: begin
        cyc_d = '0;
        tx_d  = 1'b1;
        // Ready is masked during reset so that no handshake is offered while the block is being reset.
        if (any_valid && !reset) begin
          ready[win_idx] = 1'b1;
          shift_d = bus.req_data[{win_idx, 3'b000} +: 8];
          grant_d = win_idx;
          last_d  = win_idx;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cyc_d   = '0;
          tx_d    = shift_q[0];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cyc_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cyc_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  cyc_bound_a: assert property (@(posedge clk) disable iff (reset) 32'(cyc_q) < BC_SAFE)
    else $fatal(1, "uart_tx_arbiter: bit-period counter overran");

  assign bus.req_ready = ready;
  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.grant_id  = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with BIT_CYC=8 and NREQ=4.
// It uses an IDLE priority table, followed by hand-written frame sequences.
module tb_uart_tx_arbiter;
  localparam int unsigned NREQ    = 4;
  localparam int          BIT_CYC = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .BR   (1000000),
    .CLKF (8000000),
    .NREQ (NREQ)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cyc = 0;
  int prev_hs;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] d);
    bus.req_valid[i]      = v;
    bus.req_data[8*i +: 8] = d;
  endtask

  // This task waits for the grant of idx and then checks every cycle of the 8N1 frame.
  task automatic run_frame(input int idx, input logic [7:0] d, input bit drop, input logic [7:0] post_d);
    int   waited;
    logic exp_bit;
    waited = 0;
    #1;
    while (!bus.req_ready[idx] && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("grant_wait", {31'b0, bus.req_ready[idx]}, 32'd1);
    chk("ready_onehot", 32'(bus.req_ready), 32'(1) << idx);
    hs_cyc = cyc;
    @(posedge clk);
    for (int c = 0; c < 10 * BIT_CYC; c++) begin
      @(negedge clk);
      if (c == 0) begin
        chk("grant_id", 32'(bus.grant_id), 32'(idx));
        if (drop) bus.req_valid[idx] = 1'b0;
        bus.req_data[8*idx +: 8] = post_d;
      end
      if (c < BIT_CYC) exp_bit = 1'b0;
      else if (c >= 9 * BIT_CYC) exp_bit = 1'b1;
      else exp_bit = d[c/BIT_CYC - 1];
      chk("frame_tx", {31'b0, bus.tx}, {31'b0, exp_bit});
      chk("frame_busy", {31'b0, bus.busy}, 32'd1);
      chk("frame_ready", 32'(bus.req_ready), 32'd0);
    end
    @(negedge clk);
    chk("end_busy", {31'b0, bus.busy}, 32'd0);
    chk("end_tx", {31'b0, bus.tx}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'b0001, 4'b0001};
    vecs[1] = '{4'b0110, 4'b0010};
    vecs[2] = '{4'b1000, 4'b1000};
    vecs[3] = '{4'b1100, 4'b0100};
    vecs[4] = '{4'b0000, 4'b0000};
    vecs[5] = '{4'b1111, 4'b0001};

    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", {31'b0, bus.tx}, 32'd1);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_grant", 32'(bus.grant_id), 32'd0);
    bus.req_valid = 4'b1111;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b0;

    // This loop checks the IDLE priority from the reset pointer. Valid is withdrawn before each edge.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 bus.req_valid = vecs[i].valid;
      #2;
      chk("tbl_ready", 32'(bus.req_ready), 32'(vecs[i].exp_ready));
      chk("tbl_tx", {31'b0, bus.tx}, 32'd1);
      chk("tbl_busy", {31'b0, bus.busy}, 32'd0);
      bus.req_valid = '0;
    end
    @(negedge clk);

    // The first scenario sends a single 0xA5 frame from req0.
    set_req(0, 1'b1, 8'hA5);
    run_frame(0, 8'hA5, 1'b1, 8'hA5);
    repeat (10) begin
      @(negedge clk);
      chk("idle_after_a5", {31'b0, bus.busy}, 32'd0);
    end

    // The second scenario holds all requesters valid from reset. The grants must rotate, with 81-cycle frame spacing.
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 8'h11);
    set_req(1, 1'b1, 8'h22);
    set_req(2, 1'b1, 8'h3C);
    set_req(3, 1'b1, 8'h81);
    for (int k = 0; k < 5; k++) begin
      case (k % 4)
        0: run_frame(0, 8'h11, 1'b0, 8'h11);
        1: run_frame(1, 8'h22, 1'b0, 8'h22);
        2: run_frame(2, 8'h3C, 1'b0, 8'h3C);
        default: run_frame(3, 8'h81, 1'b0, 8'h81);
      endcase
      if (k > 0) chk("frame_spacing", 32'(hs_cyc - prev_hs), 32'd81);
      prev_hs = hs_cyc;
    end
    bus.req_valid = '0;

    // The fifth scenario changes the data after the handshake. The line must carry the latched 0x00, and no refire may follow.
    set_req(1, 1'b1, 8'h00);
    run_frame(1, 8'h00, 1'b1, 8'hFF);
    repeat (20) begin
      @(negedge clk);
      chk("no_refire_busy", {31'b0, bus.busy}, 32'd0);
      chk("no_refire_ready", 32'(bus.req_ready), 32'd0);
    end

    // The third scenario starts with last_grant=1 and valid on requesters 0 and 3. The grant must go to 3 and then to 0.
    set_req(0, 1'b1, 8'h5A);
    set_req(3, 1'b1, 8'hC3);
    run_frame(3, 8'hC3, 1'b1, 8'hC3);
    prev_hs = hs_cyc;
    run_frame(0, 8'h5A, 1'b1, 8'h5A);
    chk("rr_spacing", 32'(hs_cyc - prev_hs), 32'd81);

    // The fourth scenario resets mid-frame. The frame is aborted, and the pointer returns to requester 0.
    set_req(2, 1'b1, 8'hF0);
    #1;
    chk("t4_ready", 32'(bus.req_ready), 32'b0100);
    @(posedge clk);
    set_req(0, 1'b1, 8'h96);
    repeat (30) @(negedge clk);
    chk("t4_busy_pre", {31'b0, bus.busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_abort_tx", {31'b0, bus.tx}, 32'd1);
    chk("t4_abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("t4_abort_ready", 32'(bus.req_ready), 32'd0);
    chk("t4_abort_grant", 32'(bus.grant_id), 32'd0);
    reset = 1'b0;
    #1;
    chk("t4_rr_reset", 32'(bus.req_ready), 32'b0001);
    run_frame(0, 8'h96, 1'b1, 8'h96);
    run_frame(2, 8'hF0, 1'b1, 8'hF0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
